// File: rtl/vocos_pkg.sv
// Shared types for the vocoder datapath: band samples, envelopes and the rectifier helper.
package vocos_pkg;

  typedef logic signed [63:0] sample_t;
  typedef logic        [63:0] env_t;

  localparam env_t    SAMPLE_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam sample_t SAMPLE_MIN = 64'sh8000_0000_0000_0000;

  // Full-wave rectify; the most negative sample saturates so the result fits in 63 bits.
  function automatic env_t abs_sat(input sample_t s);
    if (s == SAMPLE_MIN) return SAMPLE_MAX;
    else if (s[63])      return env_t'(-s);
    else                 return env_t'(s);
  endfunction

endpackage

// File: rtl/envelope_follower_smoother.sv
// One-pole attack/release smoother holding the envelope register.
module env_smoother
  import vocos_pkg::*;
#(
  parameter int unsigned ATTACK_SHIFT  = 2,
  parameter int unsigned RELEASE_SHIFT = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  env_t abs_q,
  output env_t env,
  output env_t env_next
);

  // Steps always land between env and abs_q, so env stays within 63 bits.
  always_comb begin
    env_next = env;
    if (en) begin
      if (abs_q > env) env_next = env + ((abs_q - env) >> ATTACK_SHIFT);
      else             env_next = env - ((env - abs_q) >> RELEASE_SHIFT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) env <= '0;
    else        env <= env_next;
  end

endmodule

// File: rtl/envelope_follower.sv
// Band envelope follower: rectify, smooth, decimate, and hand off over valid/ready.
module envelope_follower
  import vocos_pkg::*;
#(
  parameter int unsigned ATTACK_SHIFT  = 2,
  parameter int unsigned RELEASE_SHIFT = 6,
  parameter int unsigned DECIM         = 64
) (
  input  logic    clk_in,
  input  logic    rst_n_in,
  input  sample_t sample_in,
  input  logic    sample_valid_in,
  output env_t    env_out,
  output logic    env_valid_out,
  input  logic    env_ready_in,
  output logic    overrun_out
);

  localparam logic [15:0] DECIM_LAST = 16'(DECIM - 1);

  env_t        abs_q;
  logic        s1_valid;
  logic [15:0] cnt;
  env_t        env;
  env_t        env_next;
  logic        load;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      abs_q    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= sample_valid_in;
      if (sample_valid_in) abs_q <= abs_sat(sample_in);
    end
  end

  env_smoother #(
    .ATTACK_SHIFT (ATTACK_SHIFT),
    .RELEASE_SHIFT(RELEASE_SHIFT)
  ) u_smoother (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .en      (s1_valid),
    .abs_q   (abs_q),
    .env     (env),
    .env_next(env_next)
  );

  assign load = s1_valid && (cnt == DECIM_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)     cnt <= '0;
    else if (load)     cnt <= '0;
    else if (s1_valid) cnt <= cnt + 16'd1;
  end

  // Handshake: a value transfers on env_valid_out & env_ready_in. A load always wins and
  // keeps valid high; loading over a value nobody accepted sets the sticky overrun flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      env_out       <= '0;
      env_valid_out <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      if (load) begin
        env_out       <= env_next;
        env_valid_out <= 1'b1;
        if (env_valid_out && !env_ready_in) overrun_out <= 1'b1;
      end else if (env_valid_out && env_ready_in) begin
        env_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_envelope_follower.sv
// Directed bench for envelope_follower across three parameterisations sharing one input stream.
module tb_envelope_follower;
  import vocos_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  sample_t sample = '0;
  logic    sample_valid = 1'b0;
  logic    ready_a = 1'b1;
  logic    ready_b = 1'b1;
  logic    ready_c = 1'b1;

  env_t env_a, env_b, env_c;
  logic valid_a, valid_b, valid_c;
  logic ovr_a, ovr_b, ovr_c;

  int n_checks = 0;
  int n_fail = 0;

  localparam sample_t S_MIN = sample_t'(64'h8000_0000_0000_0000);

  always #5 clk = ~clk;

  // a: decimating instance; c: same smoothing with DECIM=1 to watch every env step.
  envelope_follower #(.ATTACK_SHIFT(2), .RELEASE_SHIFT(4), .DECIM(4)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .sample_in(sample), .sample_valid_in(sample_valid),
    .env_out(env_a), .env_valid_out(valid_a), .env_ready_in(ready_a), .overrun_out(ovr_a));

  envelope_follower #(.ATTACK_SHIFT(0), .RELEASE_SHIFT(6), .DECIM(1)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .sample_in(sample), .sample_valid_in(sample_valid),
    .env_out(env_b), .env_valid_out(valid_b), .env_ready_in(ready_b), .overrun_out(ovr_b));

  envelope_follower #(.ATTACK_SHIFT(2), .RELEASE_SHIFT(4), .DECIM(1)) dut_c (
    .clk_in(clk), .rst_n_in(rst_n), .sample_in(sample), .sample_valid_in(sample_valid),
    .env_out(env_c), .env_valid_out(valid_c), .env_ready_in(ready_c), .overrun_out(ovr_c));

  task automatic check(input string tag, input env_t obs, input env_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input sample_t s);
    sample_valid = v;
    sample = s;
    @(negedge clk);
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_env_out", env_a, 64'd0);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_overrun", 64'(ovr_a), 64'd0);

    // 1: four +1024 samples, attack
    ready_a = 1'b1;
    drive(1'b1, 64'sd1024);
    drive(1'b1, 64'sd1024);
    check("t1_env0", env_c, 64'd256);
    drive(1'b1, 64'sd1024);
    check("t1_env1", env_c, 64'd448);
    drive(1'b1, 64'sd1024);
    check("t1_env2", env_c, 64'd592);
    check("t1_no_early_valid", 64'(valid_a), 64'd0);
    drive(1'b0, 64'sd0);
    check("t1_env3", env_c, 64'd700);
    check("t1_valid", 64'(valid_a), 64'd1);
    check("t1_env_out", env_a, 64'd700);
    drive(1'b0, 64'sd0);
    check("t1_pulse_end", 64'(valid_a), 64'd0);

    // 2: -1024 samples then release on zeros
    do_reset();
    repeat (4) drive(1'b1, -64'sd1024);
    drive(1'b1, 64'sd0);
    check("t2_env3", env_c, 64'd700);
    check("t2_env_out", env_a, 64'd700);
    drive(1'b1, 64'sd0);
    check("t2_rel0", env_c, 64'd657);
    check("t2_accepted", 64'(valid_a), 64'd0);
    drive(1'b1, 64'sd0);
    check("t2_rel1", env_c, 64'd616);
    drive(1'b1, 64'sd0);
    check("t2_rel2", env_c, 64'd578);
    drive(1'b0, 64'sd0);
    check("t2_rel3", env_c, 64'd542);
    check("t2_env_out_rel", env_a, 64'd542);
    check("t2_valid_rel", 64'(valid_a), 64'd1);

    // 3: most negative sample saturates
    do_reset();
    drive(1'b1, S_MIN);
    drive(1'b0, 64'sd0);
    check("t3_sat", env_b, SAMPLE_MAX);
    check("t3_sign", 64'(env_b[63]), 64'd0);
    check("t3_valid", 64'(valid_b), 64'd1);

    // 4: consumer stalled across two periods
    do_reset();
    ready_a = 1'b0;
    repeat (5) drive(1'b1, 64'sd1024);
    check("t4_first", env_a, 64'd700);
    check("t4_first_valid", 64'(valid_a), 64'd1);
    check("t4_no_ovr_yet", 64'(ovr_a), 64'd0);
    repeat (3) drive(1'b1, 64'sd1024);
    check("t4_held", env_a, 64'd700);
    drive(1'b0, 64'sd0);
    check("t4_second", env_a, 64'd920);
    check("t4_overrun", 64'(ovr_a), 64'd1);
    check("t4_valid2", 64'(valid_a), 64'd1);
    ready_a = 1'b1;
    drive(1'b0, 64'sd0);
    check("t4_drained", 64'(valid_a), 64'd0);
    check("t4_sticky", 64'(ovr_a), 64'd1);

    // 5: accept in the same cycle as a load
    do_reset();
    check("t5_ovr_cleared", 64'(ovr_a), 64'd0);
    ready_a = 1'b0;
    repeat (8) drive(1'b1, 64'sd1024);
    check("t5_held", env_a, 64'd700);
    ready_a = 1'b1;
    drive(1'b0, 64'sd0);
    check("t5_new_value", env_a, 64'd920);
    check("t5_valid_stays", 64'(valid_a), 64'd1);
    check("t5_no_overrun", 64'(ovr_a), 64'd0);
    drive(1'b0, 64'sd0);
    check("t5_drained", 64'(valid_a), 64'd0);

    // 6: asynchronous reset mid-period
    do_reset();
    drive(1'b1, 64'sd1024);
    drive(1'b1, 64'sd1024);
    check("t6_pre_rst", env_c, 64'd256);
    sample_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_env", env_c, 64'd0);
    check("t6_async_valid", 64'(valid_c), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 64'sd1024);
    drive(1'b0, 64'sd0);
    drive(1'b0, 64'sd0);
    check("t6_no_early_out", 64'(valid_a), 64'd0);
    drive(1'b1, 64'sd1024);
    drive(1'b0, 64'sd0);
    check("t6_out_valid", 64'(valid_a), 64'd1);
    check("t6_out_value", env_a, 64'd700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
